// File: rtl/fetch_unit.sv
// MIPS instruction-fetch stage: owns the PC, drives a one-cycle synchronous
// instruction memory and the IF/ID register, and honours the branch delay slot.
`timescale 1ns/1ps
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned IMEM_AW  = 10
) (
  input  logic               clk,
  input  logic               rst,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  input  logic               imem_ready,
  input  logic               stall,
  input  logic               jump_branch,
  input  logic               jump_target,
  input  logic               use_reg,
  input  logic [31:0]        jr_pc,
  input  logic [31:0]        branch_pc,
  output logic [31:0]        pc_id,
  output logic [31:0]        instr_id,
  output logic               valid_id,
  output logic [31:0]        pc_if
);

  typedef enum logic [1:0] {BOOT, RUN, PEND} state_t;

  state_t      r_state;
  logic [31:0] r_pc_if;
  logic [31:0] r_pc_id;
  logic [31:0] r_instr_id;
  logic        r_valid_id;
  logic [31:0] r_pend_target;

  state_t      w_state_nxt;
  logic [31:0] w_pc_next;
  logic [31:0] w_pend_nxt;
  logic        w_load_id;
  logic        w_bubble_id;
  logic [31:0] w_pc_id_plus4;
  logic [31:0] w_target_raw;
  logic [31:0] w_target;
  logic        w_redirect;

  // Redirect target is derived from what currently sits in ID; jumps win over branches.
  always_comb begin
    w_pc_id_plus4 = r_pc_id + 32'd4;
    if (jump_target) begin
      w_target_raw = use_reg ? jr_pc
                             : {w_pc_id_plus4[31:28], r_instr_id[25:0], 2'b00};
    end else begin
      w_target_raw = w_pc_id_plus4 + branch_pc;
    end
    w_target   = {w_target_raw[31:2], 2'b00};
    w_redirect = (jump_target | jump_branch) & ~stall & r_valid_id;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_next   = r_pc_if;
    w_pend_nxt  = r_pend_target;
    w_load_id   = 1'b0;
    w_bubble_id = 1'b0;
    unique case (r_state)
      BOOT: begin
        w_pc_next   = RESET_PC;
        w_bubble_id = 1'b1;
        w_state_nxt = RUN;
      end
      RUN: begin
        if (!stall) begin
          if (imem_ready) begin
            w_load_id = 1'b1;
            w_pc_next = w_redirect ? w_target : r_pc_if + 32'd4;
          end else begin
            // Delay slot not yet fetched: park the target until it arrives.
            w_bubble_id = 1'b1;
            if (w_redirect) begin
              w_pend_nxt  = w_target;
              w_state_nxt = PEND;
            end
          end
        end
      end
      PEND: begin
        if (imem_ready) begin
          w_load_id   = 1'b1;
          w_pc_next   = r_pend_target;
          w_state_nxt = RUN;
        end else begin
          w_bubble_id = 1'b1;
        end
      end
      default: begin
        w_pc_next   = RESET_PC;
        w_state_nxt = BOOT;
      end
    endcase
    if (rst) w_pc_next = RESET_PC;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= BOOT;
      r_pc_if       <= RESET_PC - 32'd4;
      r_pc_id       <= '0;
      r_instr_id    <= '0;
      r_valid_id    <= 1'b0;
      r_pend_target <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc_if       <= w_pc_next;
      r_pend_target <= w_pend_nxt;
      if (w_load_id) begin
        r_pc_id    <= r_pc_if;
        r_instr_id <= imem_rdata;
        r_valid_id <= 1'b1;
      end else if (w_bubble_id) begin
        r_pc_id    <= r_pc_if;
        r_instr_id <= '0;
        r_valid_id <= 1'b0;
      end
    end
  end

  assign imem_addr = w_pc_next[IMEM_AW+1:2];
  assign pc_id     = r_pc_id;
  assign instr_id  = r_instr_id;
  assign valid_id  = r_valid_id;
  assign pc_if     = r_pc_if;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, branch/jump redirects,
// stall, redirect during memory wait states, and reset while pending.
`timescale 1ns/1ps
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        stall;
  logic        jump_branch;
  logic        jump_target;
  logic        use_reg;
  logic [31:0] jr_pc;
  logic [31:0] branch_pc;
  logic [31:0] pc_id;
  logic [31:0] instr_id;
  logic        valid_id;
  logic [31:0] pc_if;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000), .IMEM_AW(10)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_ready  (imem_ready),
    .stall       (stall),
    .jump_branch (jump_branch),
    .jump_target (jump_target),
    .use_reg     (use_reg),
    .jr_pc       (jr_pc),
    .branch_pc   (branch_pc),
    .pc_id       (pc_id),
    .instr_id    (instr_id),
    .valid_id    (valid_id),
    .pc_if       (pc_if)
  );

  // Memory returns the byte address as data, except a JAL (index 0x40) at 0x100.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'h0C00_0040;
    return a;
  endfunction

  always @(posedge clk) imem_rdata <= mem_word({20'b0, imem_addr, 2'b00});

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] addr32();
    return {22'b0, imem_addr};
  endfunction

  initial begin
    rst = 1'b1; stall = 1'b0; jump_branch = 1'b0; jump_target = 1'b0;
    use_reg = 1'b0; jr_pc = '0; branch_pc = '0; imem_ready = 1'b1;

    // Reset and sequential fetch
    tick(); tick();
    check("rst_pc_if",  pc_if,    32'hFFFF_FFFC);
    check("rst_pc_id",  pc_id,    32'h0);
    check("rst_instr",  instr_id, 32'h0);
    check("rst_valid",  {31'b0, valid_id}, 32'h0);
    check("rst_addr",   addr32(), 32'h0);
    rst = 1'b0; #1;
    check("boot_addr",  addr32(), 32'h0);
    tick();
    check("boot_valid", {31'b0, valid_id}, 32'h0);
    check("boot_pc_if", pc_if,    32'h0);
    check("run_addr",   addr32(), 32'h1);
    tick();
    check("first_valid", {31'b0, valid_id}, 32'h1);
    check("first_pc",    pc_id,    32'h0);
    check("first_instr", instr_id, 32'h0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      check("seq_pc",    pc_id,    32'(k * 4));
      check("seq_instr", instr_id, 32'(k * 4));
      check("seq_valid", {31'b0, valid_id}, 32'h1);
    end

    // Taken branch at 0x20, offset 0x10 -> 0x34
    jump_branch = 1'b1; branch_pc = 32'h10; #1;
    check("beq_addr", addr32(), 32'd13);
    tick(); jump_branch = 1'b0;
    check("beq_slot",  pc_id, 32'h24);
    check("beq_pc_if", pc_if, 32'h34);
    tick();
    check("beq_tgt", pc_id, 32'h34);

    // JR to 0x100, then J (index 0x40) from 0x100 back to 0x100
    jump_target = 1'b1; use_reg = 1'b1; jr_pc = 32'h100;
    tick(); jump_target = 1'b0; use_reg = 1'b0;
    check("jr_slot", pc_id, 32'h38);
    tick();
    check("jr_tgt",   pc_id,    32'h100);
    check("jr_instr", instr_id, 32'h0C00_0040);
    jump_target = 1'b1; #1;
    check("j_addr", addr32(), 32'h40);
    tick(); jump_target = 1'b0;
    check("j_slot", pc_id, 32'h104);
    tick();
    check("j_tgt", pc_id, 32'h100);

    // JR held off by a one-cycle stall that coincides with a wait state
    jump_target = 1'b1; use_reg = 1'b1; jr_pc = 32'h200; stall = 1'b1; imem_ready = 1'b0; #1;
    check("stall_addr0", addr32(), 32'h41);
    tick();
    check("stall_pc",    pc_id,    32'h100);
    check("stall_instr", instr_id, 32'h0C00_0040);
    check("stall_valid", {31'b0, valid_id}, 32'h1);
    check("stall_addr1", addr32(), 32'h41);
    stall = 1'b0; imem_ready = 1'b1; #1;
    check("unstall_addr", addr32(), 32'h80);
    tick(); jump_target = 1'b0; use_reg = 1'b0;
    check("unstall_slot", pc_id, 32'h104);
    tick();
    check("unstall_tgt",   pc_id,    32'h200);
    check("unstall_instr", instr_id, 32'h200);

    // Get to 0x40, then branch to 0x80 during 3 wait states
    jump_target = 1'b1; use_reg = 1'b1; jr_pc = 32'h40;
    tick(); jump_target = 1'b0; use_reg = 1'b0;
    check("jr40_slot", pc_id, 32'h204);
    tick();
    check("jr40_tgt", pc_id, 32'h40);
    jump_branch = 1'b1; branch_pc = 32'h3C; imem_ready = 1'b0;
    tick(); jump_branch = 1'b0;
    check("pend_bub1",   {31'b0, valid_id}, 32'h0);
    check("pend_bub_pc", pc_id, 32'h44);
    check("pend_pc_if",  pc_if, 32'h44);
    tick();
    check("pend_bub2", {31'b0, valid_id}, 32'h0);
    tick();
    check("pend_bub3", {31'b0, valid_id}, 32'h0);
    imem_ready = 1'b1; #1;
    check("pend_addr", addr32(), 32'h20);
    tick();
    check("pend_slot",       pc_id,    32'h44);
    check("pend_slot_instr", instr_id, 32'h44);
    check("pend_slot_valid", {31'b0, valid_id}, 32'h1);
    check("pend_pc_if_tgt",  pc_if,    32'h80);
    tick();
    check("pend_tgt", pc_id, 32'h80);

    // Reset while PEND: pending target must be discarded
    jump_branch = 1'b1; branch_pc = 32'h100; imem_ready = 1'b0;
    tick(); jump_branch = 1'b0;
    check("pend2_bub", {31'b0, valid_id}, 32'h0);
    rst = 1'b1; imem_ready = 1'b1; #1;
    check("prst_addr", addr32(), 32'h0);
    tick();
    check("prst_pc_if",  pc_if, 32'hFFFF_FFFC);
    check("prst_pc_id",  pc_id, 32'h0);
    check("prst_valid",  {31'b0, valid_id}, 32'h0);
    rst = 1'b0;
    tick();
    check("prst_boot_pc_if", pc_if, 32'h0);
    tick();
    check("prst_first_pc",    pc_id, 32'h0);
    check("prst_first_valid", {31'b0, valid_id}, 32'h1);
    tick();
    check("prst_second_pc", pc_id, 32'h4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
